// File: rtl/bootsel_pkg.sv
// Shared definitions for the boot-image selector: FSM state encoding and a
// width helper for the image index.
package bootsel_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_SEL      = 3'd2,
    ST_SEL_WAIT = 3'd3,
    ST_LOCK     = 3'd4,
    ST_BOOT     = 3'd5
  } state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bootsel_timer.sv
// Released-button timer for the boot selector. Counts cycles of released
// button and produces a one-cycle tick at either the re-arm or the select
// timeout, chosen by rearm_mode. A pressed button holds the timer at zero.
module bootsel_timer #(
  parameter int TMO_SEL_LOG   = 23,
  parameter int TMO_REARM_LOG = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_v,
  input  logic rearm_mode,
  output logic tick
);

  localparam int TW = ((TMO_SEL_LOG > TMO_REARM_LOG) ? TMO_SEL_LOG : TMO_REARM_LOG) + 1;

  logic [TW-1:0] timer;

  assign tick = rearm_mode ? timer[TMO_REARM_LOG] : timer[TMO_SEL_LOG];

  // Count released cycles; restart on press or after each tick.
  always_ff @(posedge clk) begin
    if (rst || !btn_v || tick) timer <= '0;
    else                       timer <= timer + 1'b1;
  end

endmodule

// File: rtl/boot_selector.sv
// Boot-image selection core: button-driven select / re-arm / timeout FSM,
// flash-lock handshake and warm-boot select/trigger generation.
// Optional build macro BOOTSEL_LONGPRESS_EN: a long press undoes the press
// that started it and boots immediately.
module boot_selector
  import bootsel_pkg::*;
#(
  parameter int N_IMG         = 4,
  parameter int DEF_IMG       = 2,
  parameter int DFU_IMG       = 1,
  parameter int SKIP_IMG      = 0,
  parameter int TMO_SEL_LOG   = 23,
  parameter int TMO_REARM_LOG = 17,
  parameter int LONG_LOG      = 24,
  localparam int SEL_W        = clog2(N_IMG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_v,
  input  logic             btn_f,
  output logic             lock_go,
  input  logic             lock_rdy,
  output logic [SEL_W-1:0] boot_sel,
  output logic             boot_now,
  output logic             in_sel
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             skip_lock, skip_nxt;
  logic             tick;
  logic             long_hit;

  assign in_sel = (state == ST_WAIT) || (state == ST_SEL) || (state == ST_SEL_WAIT);

  bootsel_timer #(
    .TMO_SEL_LOG  (TMO_SEL_LOG),
    .TMO_REARM_LOG(TMO_REARM_LOG)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .btn_v     (btn_v),
    .rearm_mode(state == ST_SEL_WAIT),
    .tick      (tick)
  );

`ifdef BOOTSEL_LONGPRESS_EN
  logic [LONG_LOG:0] hold;
  logic [SEL_W-1:0]  prev_sel;

  assign long_hit = hold[LONG_LOG];

  // Hold counter: cycles of pressed button while in select mode.
  always_ff @(posedge clk) begin
    if (rst || btn_v || !((state == ST_SEL) || (state == ST_SEL_WAIT))) hold <= '0;
    else if (!long_hit)                                                  hold <= hold + 1'b1;
  end

  // Remember the image before each increment so a long press can undo it.
  // Loading it in ST_WAIT makes an undo before any increment a no-op.
  always_ff @(posedge clk) begin
    if (state == ST_WAIT)                            prev_sel <= SEL_W'(DFU_IMG);
    else if ((state == ST_SEL) && btn_f && !long_hit) prev_sel <= boot_sel;
  end
`else
  assign long_hit = 1'b0;
`endif

  // Next-state, next image index and skip-lock decision.
  always_comb begin
    state_nxt = state;
    sel_nxt   = boot_sel;
    skip_nxt  = skip_lock;
    case (state)
      ST_START: state_nxt = btn_v ? ST_LOCK : ST_WAIT;
      ST_WAIT: begin
        sel_nxt = SEL_W'(DFU_IMG);
        if (btn_v) state_nxt = ST_SEL_WAIT;
      end
      ST_SEL: begin
        if (long_hit) begin
`ifdef BOOTSEL_LONGPRESS_EN
          sel_nxt   = prev_sel;
`endif
          state_nxt = skip_lock ? ST_BOOT : ST_LOCK;
        end else if (btn_f) begin
          state_nxt = ST_SEL_WAIT;
          sel_nxt   = (boot_sel == SEL_W'(N_IMG - 1)) ? '0 : boot_sel + 1'b1;
          if (boot_sel == SEL_W'(SKIP_IMG)) skip_nxt = 1'b1;
        end else if (tick) begin
          state_nxt = skip_lock ? ST_BOOT : ST_LOCK;
        end
      end
      ST_SEL_WAIT: begin
        if (long_hit) begin
`ifdef BOOTSEL_LONGPRESS_EN
          sel_nxt   = prev_sel;
`endif
          state_nxt = skip_lock ? ST_BOOT : ST_LOCK;
        end else if (tick) begin
          state_nxt = ST_SEL;
        end
      end
      ST_LOCK: if (lock_rdy) state_nxt = ST_BOOT;
      ST_BOOT: state_nxt = ST_BOOT;
      default: state_nxt = ST_START;
    endcase
  end

  // State, image index, lock request pulse and registered boot trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_START;
      boot_sel  <= SEL_W'(DEF_IMG);
      boot_now  <= 1'b0;
      lock_go   <= 1'b0;
      skip_lock <= 1'b0;
    end else begin
      state     <= state_nxt;
      boot_sel  <= sel_nxt;
      boot_now  <= (state == ST_BOOT);
      lock_go   <= (state_nxt == ST_LOCK) && (state != ST_LOCK);
      skip_lock <= skip_nxt;
    end
  end

endmodule

// File: tb/tb_boot_selector.sv
// Bench for boot_selector with short timeouts and three images. Expected
// boot outcomes (image, number of lock requests) are queued per scenario and
// compared when the boot trigger rises.
module tb_boot_selector;

  localparam int N_IMG = 3;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_v = 1'b1;
  logic             btn_f = 1'b0;
  logic             lock_rdy = 1'b1;
  logic             lock_go;
  logic [SEL_W-1:0] boot_sel;
  logic             boot_now;
  logic             in_sel;

  typedef struct {
    int sel;
    int n_go;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   go_cnt = 0;
  logic now_d = 1'b0;

  boot_selector #(
    .N_IMG        (N_IMG),
    .DEF_IMG      (2),
    .DFU_IMG      (1),
    .SKIP_IMG     (0),
    .TMO_SEL_LOG  (4),
    .TMO_REARM_LOG(2),
    .LONG_LOG     (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_v   (btn_v),
    .btn_f   (btn_f),
    .lock_go (lock_go),
    .lock_rdy(lock_rdy),
    .boot_sel(boot_sel),
    .boot_now(boot_now),
    .in_sel  (in_sel)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: count lock requests and score each boot against the queue.
  always @(negedge clk) begin
    if (rst) go_cnt = 0;
    else if (lock_go) go_cnt = go_cnt + 1;
    if (boot_now && !now_d) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_boot", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("boot_sel", int'(boot_sel), e.sel);
        check_eq("boot_lock_go_count", go_cnt, e.n_go);
      end
    end
    now_d = boot_now;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic bv);
    @(negedge clk);
    rst   = 1'b1;
    btn_v = bv;
    btn_f = 1'b0;
    idle(2);
    check_eq("rst_boot_sel", int'(boot_sel), 2);
    check_eq("rst_boot_now", int'(boot_now), 0);
    check_eq("rst_lock_go", int'(lock_go), 0);
    check_eq("rst_in_sel", int'(in_sel), 0);
    rst = 1'b0;
  endtask

  // Press for 'hold' cycles; returns boot_sel one cycle after the press edge.
  task automatic press(input int hold, output int sel_after);
    btn_v = 1'b0;
    btn_f = 1'b1;
    @(negedge clk);
    sel_after = int'(boot_sel);
    btn_f = 1'b0;
    repeat (hold - 1) @(negedge clk);
    btn_v = 1'b1;
  endtask

  // Start with button held, release, and wait until ST_SEL is reached.
  task automatic enter_sel();
    do_reset(1'b0);
    idle(3);
    check_eq("wait_in_sel", int'(in_sel), 1);
    check_eq("wait_boot_sel", int'(boot_sel), 1);
    btn_v = 1'b1;
    idle(6);
    check_eq("sel_in_sel", int'(in_sel), 1);
  endtask

  task automatic wait_boot(input int budget);
    for (int i = 0; i < budget && !boot_now; i++) @(negedge clk);
    check_eq("boot_seen", int'(boot_now), 1);
    @(negedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic push_exp(input int sel, input int n_go);
    exp_t e;
    e.sel  = sel;
    e.n_go = n_go;
    exp_q.push_back(e);
  endtask

  initial begin
    int s;

    // Immediate boot: released at start, default image, one lock request.
    lock_rdy = 1'b1;
    do_reset(1'b1);
    push_exp(2, 1);
    @(negedge clk);
    check_eq("imm_lock_go_pulse", int'(lock_go), 1);
    @(negedge clk);
    check_eq("imm_lock_go_low", int'(lock_go), 0);
    check_eq("imm_boot_now_early", int'(boot_now), 0);
    @(negedge clk);
    check_eq("imm_boot_now_cycle3", int'(boot_now), 1);
    idle(3);
    check_eq("imm_boot_now_sticky", int'(boot_now), 1);
    check_eq("imm_lock_go_once", go_cnt, 1);

    // Select mode entered, no presses: DFU image boots after the timeout.
    do_reset(1'b0);
    idle(10);
    check_eq("dfu_in_sel", int'(in_sel), 1);
    check_eq("dfu_boot_sel", int'(boot_sel), 1);
    push_exp(1, 1);
    btn_v = 1'b1;
    idle(20);
    check_eq("dfu_no_early_lock", go_cnt, 0);
    wait_boot(40);

    // Three presses wrap 1->2->0->1; the press at image 0 sets skip-lock.
    enter_sel();
    push_exp(1, 0);
    press(3, s);
    check_eq("step_1_to_2", s, 2);
    idle(6);
    press(3, s);
    check_eq("step_2_to_0", s, 0);
    idle(6);
    press(3, s);
    check_eq("step_0_to_1", s, 1);
    wait_boot(60);

    // Presses during re-arm are ignored; landing on image 0 still locks.
    enter_sel();
    push_exp(0, 1);
    press(2, s);
    check_eq("step_a_1_to_2", s, 2);
    idle(1);
    press(2, s);
    check_eq("rearm_press_ignored", s, 2);
    idle(6);
    press(2, s);
    check_eq("step_a_2_to_0", s, 0);
    wait_boot(60);

    // Stuck in ST_LOCK, then reset: back to start values.
    lock_rdy = 1'b0;
    enter_sel();
    press(2, s);
    idle(6);
    press(2, s);
    for (int i = 0; i < 60 && go_cnt == 0; i++) @(negedge clk);
    check_eq("lock_go_seen", go_cnt, 1);
    idle(20);
    check_eq("lock_hold_sel", int'(boot_sel), 0);
    check_eq("lock_hold_no_boot", int'(boot_now), 0);
    check_eq("lock_hold_go_low", int'(lock_go), 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("lock_rst_boot_sel", int'(boot_sel), 2);
    check_eq("lock_rst_lock_go", int'(lock_go), 0);
    check_eq("lock_rst_in_sel", int'(in_sel), 0);
    lock_rdy = 1'b1;
    do_reset(1'b1);
    push_exp(2, 1);
    wait_boot(10);

    // Long hold at image 1.
    enter_sel();
`ifdef BOOTSEL_LONGPRESS_EN
    push_exp(1, 1);
    press(40, s);
    check_eq("long_first_step", s, 2);
    wait_boot(5);
`else
    push_exp(2, 1);
    press(40, s);
    check_eq("hold_step", s, 2);
    check_eq("hold_no_lock", go_cnt, 0);
    check_eq("hold_no_boot", int'(boot_now), 0);
    wait_boot(60);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
